// File: rtl/cory_sbd2vr.sv
// Start/done command port to valid/ready bridge.
// Each accepted i_start queues one word. Words leave at the queue head on o_v/o_d
// and are retired by i_r. One o_done pulse is returned for each retired word.
module cory_sbd2vr #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TMO   = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic [N-1:0] i_data,
  output logic         o_busy,
  output logic         o_full,
  output logic         o_done,
  output logic         o_v,
  output logic [N-1:0] o_d,
  input  logic         i_r,
  output logic         o_err_ovf,
  output logic         o_tmo,
  input  logic         i_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          v_q, full_q, done_q, err_q, tmo_q;
  logic          push, pop, drop, tmo_set;

  // The full decision uses the current count only, so a pop cannot rescue a push
  assign push = i_start & ~full_q;
  assign drop = i_start & full_q;
  assign pop  = v_q & i_r;

  // Next occupancy; a simultaneous push and pop leave it unchanged
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Word storage, cleared so o_d reads zero out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Registered status, done pulse and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q    <= 1'b0;
      full_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      v_q    <= (count_d != '0);
      full_q <= (count_d == CW'(DEPTH));
      done_q <= pop;
      // A set event in the same cycle as i_clr keeps the flag high
      err_q  <= drop | (err_q & ~i_clr);
      tmo_q  <= tmo_set | (tmo_q & ~i_clr);
    end
  end

  if (TMO > 0) begin : g_tmo
    localparam int unsigned SW = $clog2(TMO + 1);
    logic [SW-1:0] stall_q;
    logic          stalled;

    assign stalled = v_q & ~i_r;
    // o_tmo is set only on the step into TMO, so i_clr is not undone by saturation
    assign tmo_set = stalled && (stall_q == SW'(TMO - 1));

    // Count stalled cycles at the head, saturating at TMO
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stall_q <= '0;
      end else if (!stalled) begin
        stall_q <= '0;
      end else if (stall_q != SW'(TMO)) begin
        stall_q <= stall_q + SW'(1);
      end
    end
  end else begin : g_no_tmo
    assign tmo_set = 1'b0;
  end

  assign o_v       = v_q;
  assign o_busy    = v_q;
  assign o_full    = full_q;
  assign o_done    = done_q;
  assign o_d       = mem_q[rd_ptr_q];
  assign o_err_ovf = err_q;
  assign o_tmo     = tmo_q;

endmodule

// File: tb/tb_cory_sbd2vr.sv
// Testbench for cory_sbd2vr. A queue-level reference model tracks the expected state.
// Directed tables and sequences cover the corner cases, then random traffic follows.
module tb_cory_sbd2vr;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_start = 1'b0;
  logic [N-1:0] i_data = '0;
  logic         i_r = 1'b0;
  logic         i_clr = 1'b0;
  logic         o_busy, o_full, o_done, o_v, o_err_ovf, o_tmo;
  logic [N-1:0] o_d;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_done, m_err, m_tmo;
  int         m_stall;

  cory_sbd2vr #(.N(N), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_data    (i_data),
    .o_busy    (o_busy),
    .o_full    (o_full),
    .o_done    (o_done),
    .o_v       (o_v),
    .o_d       (o_d),
    .i_r       (i_r),
    .o_err_ovf (o_err_ovf),
    .o_tmo     (o_tmo),
    .i_clr     (i_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_done  = 0;
    m_err   = 0;
    m_tmo   = 0;
    m_stall = 0;
  endtask

  // One clock of the model, given the inputs applied for that cycle
  task automatic model_step(input bit s, input logic [7:0] d, input bit r, input bit c);
    bit full;
    bit pop;
    bit stalled;
    bit tset;
    full    = (mq.size() == DEPTH);
    pop     = (mq.size() != 0) && r;
    stalled = (mq.size() != 0) && !r;
    tset    = 0;
    if (stalled) begin
      if (m_stall < int'(TMO)) begin
        m_stall++;
        if (m_stall == int'(TMO)) tset = 1;
      end
    end else begin
      m_stall = 0;
    end
    m_err  = (s && full) ? 1'b1 : (c ? 1'b0 : m_err);
    m_tmo  = tset ? 1'b1 : (c ? 1'b0 : m_tmo);
    m_done = pop;
    if (pop) void'(mq.pop_front());
    if (s && !full) mq.push_back(d);
  endtask

  task automatic check_model();
    chk("v",    o_v,       mq.size() != 0);
    chk("busy", o_busy,    mq.size() != 0);
    chk("full", o_full,    mq.size() == DEPTH);
    chk("done", o_done,    m_done);
    chk("err",  o_err_ovf, m_err);
    chk("tmo",  o_tmo,     m_tmo);
    if (mq.size() != 0) chk("d", o_d, mq[0]);
  endtask

  // Drive one cycle of inputs, step the model, then sample just after the edge
  task automatic cycle(input bit s, input logic [7:0] d, input bit r, input bit c);
    i_start = s;
    i_data  = d;
    i_r     = r;
    i_clr   = c;
    model_step(s, d, r, c);
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    bit         s;
    logic [7:0] d;
    bit         r;
    bit         c;
    bit         ev;
    logic [7:0] ed;
    bit         efull;
    bit         edone;
    bit         eerr;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] seq[$];
  int         n;

  initial begin
    // Hand-computed vectors for the single-word pass and the overflow fill/drain
    vecs.push_back('{1, 8'hA5, 1, 0, 1, 8'hA5, 0, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 8'h11, 0, 0, 1, 8'h11, 0, 0, 0});
    vecs.push_back('{1, 8'h22, 0, 0, 1, 8'h11, 0, 0, 0});
    vecs.push_back('{1, 8'h33, 0, 0, 1, 8'h11, 0, 0, 0});
    vecs.push_back('{1, 8'h44, 0, 0, 1, 8'h11, 1, 0, 0});
    vecs.push_back('{1, 8'h55, 0, 0, 1, 8'h11, 1, 0, 1});
    vecs.push_back('{0, 8'h00, 1, 0, 1, 8'h22, 0, 1, 1});
    vecs.push_back('{0, 8'h00, 1, 0, 1, 8'h33, 0, 1, 1});
    vecs.push_back('{0, 8'h00, 1, 0, 1, 8'h44, 0, 1, 1});
    vecs.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1});
    vecs.push_back('{0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0});

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v", o_v, 0);
    chk("rst_d", o_d, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_full", o_full, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err_ovf, 0);
    chk("rst_tmo", o_tmo, 0);
    @(negedge clk);
    reset = 1'b0;

    // Tests 1 and 2 as a vector table
    foreach (vecs[i]) begin
      cycle(vecs[i].s, vecs[i].d, vecs[i].r, vecs[i].c);
      chk($sformatf("tbl%0d_v", i), o_v, vecs[i].ev);
      if (vecs[i].ev) chk($sformatf("tbl%0d_d", i), o_d, vecs[i].ed);
      chk($sformatf("tbl%0d_full", i), o_full, vecs[i].efull);
      chk($sformatf("tbl%0d_done", i), o_done, vecs[i].edone);
      chk($sformatf("tbl%0d_err", i), o_err_ovf, vecs[i].eerr);
    end

    // Test 3: two words held while pushing and popping together
    seq = '{8'hB0, 8'hB1};
    cycle(1, 8'hB0, 0, 0);
    cycle(1, 8'hB1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      seq.push_back(8'h60 + 8'(i));
      cycle(1, 8'h60 + 8'(i), 1, 0);
      chk("t3_d", o_d, seq[i + 1]);
      chk("t3_full", o_full, 0);
      chk("t3_done", o_done, 1);
    end
    repeat (3) cycle(0, 8'h00, 1, 0);
    chk("t3_empty", o_v, 0);

    // Test 4: stall timeout, clear, then a single retire
    cycle(1, 8'h4D, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      cycle(0, 8'h00, 0, 0);
      chk("t4_tmo", o_tmo, k >= int'(TMO));
      chk("t4_d", o_d, 8'h4D);
    end
    cycle(0, 8'h00, 0, 1);
    chk("t4_clr", o_tmo, 0);
    cycle(0, 8'h00, 1, 0);
    chk("t4_done", o_done, 1);
    cycle(0, 8'h00, 0, 0);
    chk("t4_done_once", o_done, 0);

    // Test 5: reset asserted mid-stream with three words pending
    cycle(1, 8'hC1, 0, 0);
    cycle(1, 8'hC2, 0, 0);
    cycle(1, 8'hC3, 0, 0);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("t5_v", o_v, 0);
    chk("t5_busy", o_busy, 0);
    chk("t5_full", o_full, 0);
    chk("t5_done", o_done, 0);
    chk("t5_d", o_d, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 8'h00, 1, 0);
      chk("t5_post_v", o_v, 0);
      chk("t5_post_done", o_done, 0);
    end

    // Test 6: push while full with a pop in the same cycle
    cycle(1, 8'hD0, 0, 0);
    cycle(1, 8'hD1, 0, 0);
    cycle(1, 8'hD2, 0, 0);
    cycle(1, 8'hD3, 0, 0);
    chk("t6_full", o_full, 1);
    cycle(1, 8'h66, 1, 0);
    chk("t6_err", o_err_ovf, 1);
    chk("t6_full_after", o_full, 0);
    chk("t6_d", o_d, 8'hD1);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(0, 8'h00, 1, 0);
      if (o_done) n++;
    end
    chk("t6_dones", n, 3);
    cycle(0, 8'h00, 0, 1);

    // Random traffic against the model, first stall-heavy then flowing
    for (int k = 0; k < 600; k++) begin
      bit s, r, c;
      s = ($urandom_range(0, 2) != 0);
      r = (k < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      cycle(s, 8'($urandom), r, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
